// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and width helpers for the button conditioner
package btn_pkg;

    localparam int DEF_NUM_BTNS      = 3;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_DB_CYCLES     = 16;
    localparam int DEF_REPEAT_EN     = 1;
    localparam int DEF_REPEAT_DELAY  = 32;
    localparam int DEF_REPEAT_PERIOD = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int rep_cnt_width(input int delay, input int period);
        return clog2(((delay > period) ? delay : period) + 1);
    endfunction

endpackage

// File: rtl/btn_if.sv
// rtl/btn_if.sv - raw button inputs and conditioned output strobes
interface btn_if #(
    parameter int NUM_BTNS = 3
);
    logic [NUM_BTNS-1:0] btn_in;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;
    logic [NUM_BTNS-1:0] btn_release;
    logic [NUM_BTNS-1:0] btn_repeat;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one channel: synchroniser, debounce, edge pulses, auto-repeat
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_EN     = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int DCW = clog2(DB_CYCLES + 1);
    localparam int RCW = rep_cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DCW-1:0]         dcnt_q, dcnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sync_bit;
    logic                   accept;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], btn_in};
        sync_bit  = sync_q[SYNC_STAGES-1];
        accept    = (sync_bit != level_q) && (dcnt_q == DB_LAST);
        // Any sample agreeing with the accepted level restarts the stability window.
        dcnt_d    = ((sync_bit == level_q) || accept) ? '0 : dcnt_q + 1'b1;
        level_d   = accept ? sync_bit : level_q;
        press_d   = accept & sync_bit;
        release_d = accept & ~sync_bit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            dcnt_q    <= dcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

    if (REPEAT_EN != 0) begin : g_repeat
        logic [RCW-1:0] rcnt_q, rcnt_d;
        logic           rep_q, rep_d;

        always_comb begin
            rcnt_d = rcnt_q;
            rep_d  = 1'b0;
            if (press_d) begin
                rcnt_d = RCW'(REPEAT_DELAY - 1);
            end else if (release_d || !level_q) begin
                rcnt_d = '0;
            end else if (rcnt_q == '0) begin
                rep_d  = 1'b1;
                rcnt_d = RCW'(REPEAT_PERIOD - 1);
            end else begin
                rcnt_d = rcnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rcnt_q <= '0;
                rep_q  <= 1'b0;
            end else begin
                rcnt_q <= rcnt_d;
                rep_q  <= rep_d;
            end
        end

        assign repeat_o = rep_q;
    end else begin : g_no_repeat
        assign repeat_o = 1'b0;
    end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N independent button conditioning channels
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTNS      = DEF_NUM_BTNS,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_EN     = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    btn_if.slave bus
);

    logic [NUM_BTNS-1:0] level_w;
    logic [NUM_BTNS-1:0] press_w;
    logic [NUM_BTNS-1:0] release_w;
    logic [NUM_BTNS-1:0] repeat_w;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        btn_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .btn_in    (bus.btn_in[i]),
            .level_o   (level_w[i]),
            .press_o   (press_w[i]),
            .release_o (release_w[i]),
            .repeat_o  (repeat_w[i])
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;
    assign bus.btn_repeat  = repeat_w;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - randomized and directed bench for btn_conditioner
module tb_btn_conditioner;

    localparam int NB = 3;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] btn = '0;

    always #5 clk = ~clk;

    btn_if #(.NUM_BTNS(NB)) bus_a ();
    btn_if #(.NUM_BTNS(NB)) bus_b ();

    assign bus_a.btn_in = btn;
    assign bus_b.btn_in = btn;

    btn_conditioner #(
        .NUM_BTNS(NB), .SYNC_STAGES(SS), .DB_CYCLES(DB),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_rep (.clk(clk), .reset(reset), .bus(bus_a.slave));

    btn_conditioner #(
        .NUM_BTNS(NB), .SYNC_STAGES(SS), .DB_CYCLES(DB),
        .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_norep (.clk(clk), .reset(reset), .bus(bus_b.slave));

    // Reference: history of sampled inputs; a level change is accepted once the
    // last DB synchronised samples all disagree with the current level.
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_level, m_press, m_release, m_repeat;
    int            m_since [NB];

    int n_pass  = 0;
    int n_total = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist.delete();
            m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
            for (int i = 0; i < NB; i++) m_since[i] = 0;
        end else begin
            hist.push_back(btn);
            m_press = '0; m_release = '0; m_repeat = '0;
            for (int i = 0; i < NB; i++) begin
                automatic bit all_diff = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    automatic int  idx = hist.size() - 1 - SS - j;
                    automatic logic v  = (idx >= 0) ? hist[idx][i] : 1'b0;
                    if (v == m_level[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    if (!m_level[i]) begin
                        m_level[i] = 1'b1; m_press[i] = 1'b1; m_since[i] = 0;
                    end else begin
                        m_level[i] = 1'b0; m_release[i] = 1'b1;
                    end
                end else if (m_level[i]) begin
                    m_since[i] = m_since[i] + 1;
                    if (m_since[i] >= RD && ((m_since[i] - RD) % RP) == 0) m_repeat[i] = 1'b1;
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        btn   = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat,
             bus_b.btn_level, bus_b.btn_press, bus_b.btn_release, bus_b.btn_repeat} !== 24'h0)
            $display("FAIL reset_state got %h exp 000000",
                     {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat,
                      bus_b.btn_level, bus_b.btn_press, bus_b.btn_release, bus_b.btn_repeat});
        else n_pass++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean_press();
        btn = 3'b001;
        for (int c = 0; c < 24; c++) begin
            if (c == 12) btn = 3'b000;
            @(negedge clk);
            n_total++;
            if ({bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat} !==
                {m_level, m_press, m_release, m_repeat})
                $display("FAIL clean_press cyc %0d got %b exp %b", c,
                         {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat},
                         {m_level, m_press, m_release, m_repeat});
            else n_pass++;
            if (c == 5) begin
                n_total++;
                if ({bus_a.btn_level, bus_a.btn_press} !== 6'b001_001)
                    $display("FAIL clean_press_edge5 got %b exp 001001",
                             {bus_a.btn_level, bus_a.btn_press});
                else n_pass++;
            end
            if (c == 6) begin
                n_total++;
                if (bus_a.btn_press !== 3'b000)
                    $display("FAIL clean_press_one_cycle got %b exp 000", bus_a.btn_press);
                else n_pass++;
            end
        end
    endtask

    task automatic test_bounce();
        logic [6:0] pattern = 7'b0110111;
        logic [NB-1:0] seen = '0;
        for (int c = 0; c < 20; c++) begin
            btn = (c < 7) ? {1'b0, pattern[c], 1'b0} : 3'b000;
            @(negedge clk);
            seen = seen | bus_a.btn_level | bus_a.btn_press | bus_a.btn_release;
            n_total++;
            if ({bus_a.btn_level, bus_a.btn_press, bus_a.btn_release} !== {m_level, m_press, m_release})
                $display("FAIL bounce cyc %0d got %b exp %b", c,
                         {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release},
                         {m_level, m_press, m_release});
            else n_pass++;
        end
        n_total++;
        if (seen !== 3'b000) $display("FAIL bounce_any got %b exp 000", seen);
        else n_pass++;
    endtask

    task automatic test_hold_repeat();
        int reps = 0;
        int rel_cyc = -1;
        btn = 3'b100;
        for (int c = 0; c < 50; c++) begin
            if (c == 30) btn = 3'b000;
            @(negedge clk);
            if (bus_a.btn_repeat[2]) reps++;
            if (bus_a.btn_release[2]) rel_cyc = c;
            n_total++;
            if ({bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat,
                 bus_b.btn_repeat} !== {m_level, m_press, m_release, m_repeat, 3'b000})
                $display("FAIL hold_repeat cyc %0d got %b exp %b", c,
                         {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat,
                          bus_b.btn_repeat}, {m_level, m_press, m_release, m_repeat, 3'b000});
            else n_pass++;
        end
        n_total++;
        if (reps != 6) $display("FAIL hold_repeat_count got %0d exp 6", reps);
        else n_pass++;
        n_total++;
        if (rel_cyc != 35) $display("FAIL hold_release_cycle got %0d exp 35", rel_cyc);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        btn = 3'b111;
        for (int c = 0; c < 36; c++) begin
            if (c == 16) btn = 3'b000;
            @(negedge clk);
            n_total++;
            if ({bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat,
                 bus_b.btn_level, bus_b.btn_press, bus_b.btn_release} !==
                {m_level, m_press, m_release, m_repeat, m_level, m_press, m_release})
                $display("FAIL simultaneous cyc %0d got %b exp %b", c,
                         {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat},
                         {m_level, m_press, m_release, m_repeat});
            else n_pass++;
            if (c == 5 || c == 21) begin
                n_total++;
                if ((c == 5 ? bus_a.btn_press : bus_a.btn_release) !== 3'b111)
                    $display("FAIL simultaneous_edge cyc %0d got %b exp 111", c,
                             (c == 5 ? bus_a.btn_press : bus_a.btn_release));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int rel_seen = 0;
        btn = 3'b001;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat,
             bus_b.btn_level} !== 15'h0)
            $display("FAIL reset_async got %b exp 0",
                     {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat,
                      bus_b.btn_level});
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rel_seen += int'(bus_a.btn_release[0]);
            n_total++;
            if ({bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat} !==
                {m_level, m_press, m_release, m_repeat})
                $display("FAIL reset_mid_hold cyc %0d got %b exp %b", c,
                         {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat},
                         {m_level, m_press, m_release, m_repeat});
            else n_pass++;
            if (c == 5) begin
                n_total++;
                if (bus_a.btn_press !== 3'b001)
                    $display("FAIL reset_repress got %b exp 001", bus_a.btn_press);
                else n_pass++;
            end
        end
        n_total++;
        if (rel_seen != 0) $display("FAIL reset_no_release got %0d exp 0", rel_seen);
        else n_pass++;
        btn = 3'b000;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        int remain [NB];
        for (int i = 0; i < NB; i++) remain[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (remain[i] == 0) begin
                    btn[i]    = (c < 580) ? 1'($urandom_range(0, 1)) : 1'b0;
                    remain[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30))
                                                            : int'($urandom_range(1, 6));
                end
                remain[i]--;
            end
            @(negedge clk);
            n_total++;
            if ({bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat,
                 bus_b.btn_level, bus_b.btn_press, bus_b.btn_release, bus_b.btn_repeat} !==
                {m_level, m_press, m_release, m_repeat, m_level, m_press, m_release, 3'b000})
                $display("FAIL random cyc %0d got %b exp %b", c,
                         {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat,
                          bus_b.btn_level, bus_b.btn_press, bus_b.btn_release, bus_b.btn_repeat},
                         {m_level, m_press, m_release, m_repeat, m_level, m_press, m_release, 3'b000});
            else n_pass++;
        end
        btn = '0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Parametrised, N-channel successor to the scoreboard pushbutton input conditioner.
- Per channel it:
  - synchronises a raw button with a configurable-depth flop chain;
  - debounces it with a stability counter;
  - produces a debounced level plus single-cycle press, release and auto-repeat pulses.
- Sits between board pins and the scoreboard/game control FSMs. Every output is a registered clock enable.

Parameters:
- NUM_BTNS, 3, number of independent button channels (>=1)
- SYNC_STAGES, 2, synchroniser depth in flops (>=2)
- DB_CYCLES, 16, consecutive stable cycles required to accept a level change (>=1)
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = repeat output tied low and repeat counters removed
- REPEAT_DELAY, 32, cycles from press pulse to first repeat pulse (>=1)
- REPEAT_PERIOD, 8, cycles between subsequent repeat pulses (>=1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  reset; one clock; reset is asynchronous and active-low
- btn_in  input  NUM_BTNS  raw asynchronous button inputs, active-high
- btn_level  output  NUM_BTNS  debounced button state
- btn_press  output  NUM_BTNS  one-cycle pulse on accepted 0->1
- btn_release  output  NUM_BTNS  one-cycle pulse on accepted 1->0
- btn_repeat  output  NUM_BTNS  one-cycle auto-repeat pulse while held

Behaviour:
- Reset (reset low, asynchronous): all sync flops, debounce counters, repeat counters and all outputs clear to 0. Releasing reset mid-press restarts the channel from "not pressed". A button already held at release therefore produces a fresh press after full latency.
- Channels are fully independent. Simultaneous activity on any subset of channels gives the same per-channel timing as single activity.
- Synchroniser: btn_in[i] shifts through SYNC_STAGES flops; sync[i] is the last stage.
- Debounce counter dcnt, width clog2(DB_CYCLES+1):
  - sync == btn_level: dcnt <= 0.
  - sync != btn_level and dcnt == DB_CYCLES-1: btn_level <= sync, dcnt <= 0.
  - Otherwise: dcnt increments.
  - Any single agreeing sample resets the count, so glitches shorter than DB_CYCLES cycles are ignored.
- Latency: an input held steady from edge E first appears on sync after edge E+SYNC_STAGES-1. btn_level and the matching press/release pulse assert after edge E+SYNC_STAGES-1+DB_CYCLES, i.e. SYNC_STAGES+DB_CYCLES-1 edges after the first sampling edge. Pulses are registered and coincide with the btn_level change.
- btn_press and btn_release are high for exactly one cycle per accepted transition and are never high together.
- Auto-repeat (REPEAT_EN=1), repeat counter rcnt, width clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
  - On the press edge, rcnt <= REPEAT_DELAY-1.
  - While btn_level is 1 and no press is occurring:
    - rcnt == 0: btn_repeat <= 1 for one cycle, rcnt <= REPEAT_PERIOD-1.
    - Otherwise: rcnt decrements.
  - Press at cycle P gives repeats at P+REPEAT_DELAY, then every REPEAT_PERIOD cycles.
  - On release, rcnt <= 0 and no repeat pulse is issued in the release cycle or afterwards.
  - btn_repeat never coincides with btn_press.

Decomposition:
- Shared package btn_pkg holds:
  - a clog2 constant function;
  - default parameter constants;
  - a helper computing repeat counter width.
- Sub-module btn_channel holds one synchroniser, debounce counter, edge pulses and repeat counter.
- Top level instantiates NUM_BTNS copies of btn_channel via generate.

Test Plan:
All scenarios use bench parameters NUM_BTNS=3, SYNC_STAGES=2, DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
- Clean press: btn_in[0] rises before edge 0 and holds -> btn_level[0]=1 and btn_press[0]=1 after edge 5 (press 1 cycle only); channels 1-2 stay 0.
- Bounce rejection: btn_in[1] toggles high 3 cycles, low 1, high 2, low -> btn_level[1], btn_press[1], btn_release[1] remain 0 throughout.
- Hold with repeat: btn_in[2] held 30 cycles from press pulse at P -> btn_repeat[2] at P+8, P+12, P+16, ..., P+28. Release pulse occurs 5 edges after input falls; no repeat after release.
- Simultaneous: all three btn_in rise on the same cycle -> all btn_press bits pulse together; all three bits fall together at release with single btn_release pulses.
- Reset mid-hold: reset low for 2 cycles while btn_in[0] held and btn_level[0]=1 -> outputs go to 0 immediately (asynchronously). After reset releases, a new btn_press[0] comes after 5 edges and no btn_release[0] is issued.
- REPEAT_EN=0 build: 40-cycle hold -> btn_repeat stays 0; press and release behave as above.
